bp_pht_scheduler: RTL and testbench

//  Sequencer/arbiter for the single-port 2-bit pattern history table (PHT). It serves two requesters:
//   - fetch lookups
//   - resolve-stage updates (buffered in a FIFO, applied as read-modify-write)

---
 rtl/bp_pht_scheduler_pkg.sv | 34 +++
 rtl/bp_pht_scheduler_if.sv | 34 +++
 rtl/bp_pht_scheduler_fifo.sv | 54 +++++
 rtl/bp_pht_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_bp_pht_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pht_scheduler_pkg.sv
// Shared types and helpers for the PHT scheduler: 2-bit counter encodings,
// the sequencer state enum, the saturating counter update and PC-to-index mapping.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_UPD_WR = 2'd2
    } bp_state_e;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] bp_sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] v_next;
        if (taken) begin
            v_next = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            v_next = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return v_next;
    endfunction

    // Word-aligned PC to table index; the caller narrows the result to idx_w bits.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input int unsigned idx_w);
        logic [31:0] v_mask;
        v_mask = (32'd1 << idx_w) - 32'd1;
        return (pc >> 2) & v_mask;
    endfunction

endpackage

// File: rtl/bp_pht_scheduler_if.sv
// Request/response and PHT RAM port bundle for bp_pht_scheduler.
// slave  : the scheduler side.
// master : fetch/execute plus the RAM macro (the RAM read data is driven from this side).
interface bp_pht_scheduler_if #(
    parameter int IDX_W = 6
);
    logic             lk_valid;
    logic             lk_ready;
    logic [31:0]      lk_pc;
    logic             lk_rsp_valid;
    logic             lk_pred;
    logic             upd_valid;
    logic             upd_ready;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata;
    logic             init_done;

    modport master (
        output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, tbl_rdata,
        input  lk_ready, lk_rsp_valid, lk_pred, upd_ready,
        input  tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
    );

    modport slave (
        input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, tbl_rdata,
        output lk_ready, lk_rsp_valid, lk_pred, upd_ready,
        output tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
    );
endinterface

// File: rtl/bp_pht_scheduler_fifo.sv
// bp_upd_fifo: small FIFO holding resolved-branch updates {index, taken}.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Storage is not reset; flushing is done by clearing the pointers.
module bp_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_taken,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [IDX_W-1:0] o_head_idx,
    output logic             o_head_taken
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [IDX_W-1:0] r_mem_idx   [DEPTH];
    logic             r_mem_taken [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty      = (r_wr_ptr == r_rd_ptr);
    assign o_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push       = i_push && !o_full;
    assign w_pop        = i_pop && !o_empty;
    assign o_head_idx   = r_mem_idx[r_rd_ptr[AW-1:0]];
    assign o_head_taken = r_mem_taken[r_rd_ptr[AW-1:0]];

    // Pointer update; push and pop in the same cycle both take effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage, written at the tail on push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_idx[r_wr_ptr[AW-1:0]]   <= i_idx;
            r_mem_taken[r_wr_ptr[AW-1:0]] <= i_taken;
        end
    end
endmodule

// File: rtl/bp_pht_scheduler.sv
// bp_pht_scheduler: single-port 2-bit PHT sequencer. Sweeps the table to
// weakly-taken after reset, then arbitrates fetch lookups (priority) against
// buffered resolve updates applied as read-modify-write.
// Optional build macro: BP_STARVE_GUARD_EN - after STARVE_LIMIT consecutive
// lookup grants with updates pending, one update is forced through.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_INIT   | writing WT to entry init_cnt, one entry per cycle
// S_IDLE   | serve lookup read, else issue head update's read, else idle
// S_UPD_WR | write saturated counter for head update and pop it
module bp_pht_scheduler
    import bp_pkg::*;
#(
    parameter int TABLE_SIZE   = 64,
    parameter int UPD_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    bp_pht_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(TABLE_SIZE);

    bp_state_e        r_state;
    logic [IDX_W-1:0] r_init_cnt;
    logic             r_init_done;
    logic             r_rsp_valid;
    logic             r_pred_hold;

    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;
    logic             w_push;
    logic             w_pop;
    logic             w_lk_block;
    logic             w_lk_grant;
    logic             w_upd_rd;
    logic             w_tbl_en;
    logic             w_tbl_we;
    logic [IDX_W-1:0] w_tbl_addr;
    logic [1:0]       w_tbl_wdata;

    assign w_lk_idx  = IDX_W'(bp_index(bus.lk_pc, IDX_W));
    assign w_upd_idx = IDX_W'(bp_index(bus.upd_pc, IDX_W));
    assign w_push    = bus.upd_valid && !w_fifo_full;
    assign w_pop     = (r_state == S_UPD_WR);

    bp_upd_fifo #(
        .DEPTH (UPD_DEPTH),
        .IDX_W (IDX_W)
    ) u_upd_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_push       (w_push),
        .i_idx        (w_upd_idx),
        .i_taken      (bus.upd_taken),
        .i_pop        (w_pop),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_head_idx   (w_head_idx),
        .o_head_taken (w_head_taken)
    );

`ifdef BP_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] r_starve_cnt;

    assign w_lk_block = !w_fifo_empty && (r_starve_cnt == SC_W'(STARVE_LIMIT));

    // Count lookup grants made while updates wait; reset once an update gets the port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_upd_rd || w_fifo_empty) begin
            r_starve_cnt <= '0;
        end else if (w_lk_grant) begin
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
        end
    end
`else
    assign w_lk_block = 1'b0;
`endif

    // Port arbitration in IDLE: lookup first unless the starve guard has tripped.
    always_comb begin
        w_lk_grant = 1'b0;
        w_upd_rd   = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.lk_valid && !w_lk_block) begin
                w_lk_grant = 1'b1;
            end else if (!w_fifo_empty) begin
                w_upd_rd = 1'b1;
            end
        end
    end

    // PHT port drive; everything is held quiet while reset is asserted so an
    // in-flight update write cannot land.
    always_comb begin
        w_tbl_en    = 1'b0;
        w_tbl_we    = 1'b0;
        w_tbl_addr  = '0;
        w_tbl_wdata = '0;
        case (r_state)
            S_INIT: begin
                w_tbl_en    = 1'b1;
                w_tbl_we    = 1'b1;
                w_tbl_addr  = r_init_cnt;
                w_tbl_wdata = WT;
            end
            S_IDLE: begin
                if (w_lk_grant) begin
                    w_tbl_en   = 1'b1;
                    w_tbl_addr = w_lk_idx;
                end else if (w_upd_rd) begin
                    w_tbl_en   = 1'b1;
                    w_tbl_addr = w_head_idx;
                end
            end
            S_UPD_WR: begin
                w_tbl_en    = 1'b1;
                w_tbl_we    = 1'b1;
                w_tbl_addr  = w_head_idx;
                w_tbl_wdata = bp_sat_update(bus.tbl_rdata, w_head_taken);
            end
            default: ;
        endcase
        if (!reset_n) begin
            w_tbl_en    = 1'b0;
            w_tbl_we    = 1'b0;
            w_tbl_addr  = '0;
            w_tbl_wdata = '0;
        end
    end

    // Sequencer state, init sweep counter and registered lookup response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_pred_hold <= 1'b0;
        end else begin
            r_rsp_valid <= w_lk_grant;
            if (r_rsp_valid) r_pred_hold <= bus.tbl_rdata[1];
            case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + IDX_W'(1);
                    if (r_init_cnt == IDX_W'(TABLE_SIZE - 1)) begin
                        r_state     <= S_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_upd_rd) r_state <= S_UPD_WR;
                end
                S_UPD_WR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    // RAM read data arrives the cycle after the read, so the prediction is
    // passed straight through in the response cycle and held afterwards.
    assign bus.lk_pred      = r_rsp_valid ? bus.tbl_rdata[1] : r_pred_hold;
    assign bus.lk_rsp_valid = r_rsp_valid;
    assign bus.lk_ready     = (r_state == S_IDLE) && !w_lk_block;
    assign bus.upd_ready    = !w_fifo_full;
    assign bus.init_done    = r_init_done;
    assign bus.tbl_en       = w_tbl_en;
    assign bus.tbl_we       = w_tbl_we;
    assign bus.tbl_addr     = w_tbl_addr;
    assign bus.tbl_wdata    = w_tbl_wdata;
endmodule

// File: tb/tb_bp_pht_scheduler.sv
// Testbench for bp_pht_scheduler: behavioural PHT RAM, scoreboard queues for
// expected table writes and lookup predictions, one task per scenario.
module tb_bp_pht_scheduler;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [7:0] exp_wr_q [$];
    logic       exp_pred_q [$];
    logic [1:0] exp_tbl [64];
    logic [1:0] ram [64];
    logic [7:0] mon_w;
    logic       mon_p;

    bp_pht_scheduler_if #(.IDX_W(6)) bus ();

    bp_pht_scheduler #(
        .TABLE_SIZE   (64),
        .UPD_DEPTH    (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PHT RAM macro model: 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.tbl_en) begin
            if (bus.tbl_we) ram[bus.tbl_addr] <= bus.tbl_wdata;
            else            bus.tbl_rdata     <= ram[bus.tbl_addr];
        end
    end

    // Scoreboard: every table write and every lookup response is matched in order.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.tbl_en && bus.tbl_we) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL tbl_write unexpected: addr=%0d wdata=%b", bus.tbl_addr, bus.tbl_wdata);
                end else begin
                    mon_w = exp_wr_q.pop_front();
                    if ({bus.tbl_addr, bus.tbl_wdata} !== mon_w) begin
                        errors++;
                        $display("FAIL tbl_write: got addr=%0d wdata=%b, want addr=%0d wdata=%b",
                                 bus.tbl_addr, bus.tbl_wdata, mon_w[7:2], mon_w[1:0]);
                    end
                end
            end
            if (bus.lk_rsp_valid) begin
                checks++;
                if (exp_pred_q.size() == 0) begin
                    errors++;
                    $display("FAIL lk_rsp unexpected: pred=%b", bus.lk_pred);
                end else begin
                    mon_p = exp_pred_q.pop_front();
                    if (bus.lk_pred !== mon_p) begin
                        errors++;
                        $display("FAIL lk_pred: got %b want %b", bus.lk_pred, mon_p);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v < 0) v = 0;
        if (v > 3) v = 3;
        return 2'(v);
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_init_sweep();
        for (int a = 0; a < 64; a++) begin
            exp_wr_q.push_back({6'(a), 2'b10});
            exp_tbl[a] = 2'b10;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 120 && exp_wr_q.size() != 0; c++) @(negedge clk);
        checks++;
        if (exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d writes still outstanding, want 0", name, exp_wr_q.size());
        end
        next_cyc();
    endtask

    task automatic push_upd(input logic [31:0] pc, input logic [5:0] idx, input logic taken);
        bus.upd_valid = 1'b1;
        bus.upd_pc    = pc;
        bus.upd_taken = taken;
        @(negedge clk);
        checks++;
        if (bus.upd_ready !== 1'b1) begin
            errors++;
            $display("FAIL upd_ready: got %b want 1", bus.upd_ready);
        end else begin
            exp_tbl[idx] = m_sat(exp_tbl[idx], taken);
            exp_wr_q.push_back({idx, exp_tbl[idx]});
        end
        next_cyc();
        bus.upd_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc, input logic [5:0] idx);
        logic exp;
        exp = exp_tbl[idx][1];
        bus.lk_valid = 1'b1;
        bus.lk_pc    = pc;
        @(negedge clk);
        checks++;
        if ({bus.lk_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr} !== {3'b110, idx}) begin
            errors++;
            $display("FAIL lookup_read: got ready/en/we=%b%b%b addr=%0d want 110 addr=%0d",
                     bus.lk_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr, idx);
        end
        exp_pred_q.push_back(exp);
        next_cyc();
        bus.lk_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.lk_rsp_valid, bus.lk_pred} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL lookup_rsp: got valid=%b pred=%b want valid=1 pred=%b",
                     bus.lk_rsp_valid, bus.lk_pred, exp);
        end
        next_cyc();
        @(negedge clk);
        checks++;
        if ({bus.lk_rsp_valid, bus.lk_pred} !== {1'b0, exp}) begin
            errors++;
            $display("FAIL lookup_hold: got valid=%b pred=%b want valid=0 pred=%b",
                     bus.lk_rsp_valid, bus.lk_pred, exp);
        end
        next_cyc();
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.lk_valid  = 1'b0;
        bus.lk_pc     = '0;
        bus.upd_valid = 1'b0;
        bus.upd_pc    = '0;
        bus.upd_taken = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.lk_ready, bus.lk_rsp_valid, bus.lk_pred, bus.init_done, bus.upd_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/rsp/pred/done/upd_rdy=%b%b%b%b%b want 00001",
                     bus.lk_ready, bus.lk_rsp_valid, bus.lk_pred, bus.init_done, bus.upd_ready);
        end
        checks++;
        if ({bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata} !== 10'd0) begin
            errors++;
            $display("FAIL reset_tbl: got en=%b we=%b addr=%0d wdata=%b want all 0",
                     bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata);
        end
    endtask

    task automatic test_init();
        int bad;
        bad = 0;
        expect_init_sweep();
        next_cyc();
        reset_n      = 1'b1;
        bus.lk_valid = 1'b1;
        bus.lk_pc    = 32'h10;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (bus.lk_ready !== 1'b0 || bus.init_done !== 1'b0) bad++;
            next_cyc();
        end
        bus.lk_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_ready: %0d sweep cycles had lk_ready or init_done high, want 0", bad);
        end
        @(negedge clk);
        checks++;
        if (bus.init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done: got %b want 1 on cycle 65", bus.init_done);
        end
        checks++;
        if (exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL init_count: %0d sweep writes missing, want 0", exp_wr_q.size());
        end
        next_cyc();
    endtask

    task automatic test_lookup();
        do_lookup(32'h10, 6'd4);
    endtask

    task automatic test_update_dec();
        push_upd(32'h10, 6'd4, 1'b0);
        push_upd(32'h10, 6'd4, 1'b0);
        wait_drain("update_dec");
        do_lookup(32'h10, 6'd4);
    endtask

    task automatic test_update_sat();
        int en_cnt;
        en_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            bus.upd_valid = (c < 3);
            bus.upd_pc    = 32'h20;
            bus.upd_taken = 1'b1;
            @(negedge clk);
            if (bus.upd_valid && bus.upd_ready) begin
                exp_tbl[8] = m_sat(exp_tbl[8], 1'b1);
                exp_wr_q.push_back({6'd8, exp_tbl[8]});
            end
            if (bus.tbl_en) en_cnt++;
            next_cyc();
        end
        bus.upd_valid = 1'b0;
        checks++;
        if (en_cnt != 6) begin
            errors++;
            $display("FAIL sat_port_cycles: got %0d port cycles want 6", en_cnt);
        end
        wait_drain("update_sat");
    endtask

    task automatic test_starve();
        localparam logic [4:0] TK = 5'b11000;
        int n, grants, grants_before, writes, first_wr, first_rd;
        logic rd_lk_ready, wr_lk_ready;
        n = 0; grants = 0; grants_before = 0; writes = 0;
        first_wr = -1; first_rd = -1;
        rd_lk_ready = 1'b1; wr_lk_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            bus.lk_valid  = 1'b1;
            bus.lk_pc     = 32'h40;
            bus.upd_valid = (n < 5);
            bus.upd_pc    = 32'h80;
            bus.upd_taken = TK[n < 5 ? n : 0];
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (bus.upd_ready !== 1'b0 || n != 4) begin
                    errors++;
                    $display("FAIL upd_full: got upd_ready=%b after %0d pushes want 0 after 4", bus.upd_ready, n);
                end
            end
            if (bus.lk_valid && bus.lk_ready) begin
                grants++;
                exp_pred_q.push_back(exp_tbl[16][1]);
            end
            if (bus.tbl_en && !bus.tbl_we && bus.tbl_addr == 6'd32 && first_rd < 0) begin
                first_rd    = c;
                rd_lk_ready = bus.lk_ready;
            end
            if (bus.tbl_en && bus.tbl_we) begin
                writes++;
                if (first_wr < 0) begin
                    first_wr      = c;
                    grants_before = grants;
                    wr_lk_ready   = bus.lk_ready;
                end
            end
            if (bus.upd_valid && bus.upd_ready) begin
                exp_tbl[32] = m_sat(exp_tbl[32], TK[n]);
                exp_wr_q.push_back({6'd32, exp_tbl[32]});
                n++;
            end
            next_cyc();
        end
        bus.lk_valid = 1'b0;
`ifdef BP_STARVE_GUARD_EN
        checks++;
        if (grants_before != 9 || first_wr != 11) begin
            errors++;
            $display("FAIL starve_guard: first write cycle %0d after %0d grants, want cycle 11 after 9",
                     first_wr, grants_before);
        end
        checks++;
        if (first_rd != 10 || rd_lk_ready !== 1'b0 || wr_lk_ready !== 1'b0) begin
            errors++;
            $display("FAIL starve_ready: read cycle %0d lk_ready rd=%b wr=%b, want cycle 10 with 0 0",
                     first_rd, rd_lk_ready, wr_lk_ready);
        end
`else
        checks++;
        if (writes != 0 || first_rd >= 0 || grants != 30) begin
            errors++;
            $display("FAIL strict_priority: %0d writes, update read cycle %0d, %0d grants; want 0, none, 30",
                     writes, first_rd, grants);
        end
`endif
        for (int c = 0; c < 60 && n < 5; c++) begin
            bus.upd_valid = 1'b1;
            bus.upd_taken = TK[n];
            @(negedge clk);
            if (bus.upd_ready) begin
                exp_tbl[32] = m_sat(exp_tbl[32], TK[n]);
                exp_wr_q.push_back({6'd32, exp_tbl[32]});
                n++;
            end
            next_cyc();
        end
        bus.upd_valid = 1'b0;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL starve_push: got %0d accepted updates want 5", n);
        end
        wait_drain("starve");
    endtask

    task automatic test_reset_mid();
        int busy;
        busy = 0;
        bus.upd_valid = 1'b1;
        bus.upd_pc    = 32'h10;
        bus.upd_taken = 1'b1;
        next_cyc();
        bus.upd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.tbl_en, bus.tbl_we, bus.tbl_addr} !== {2'b10, 6'd4}) begin
            errors++;
            $display("FAIL mid_read: got en=%b we=%b addr=%0d want 1 0 4", bus.tbl_en, bus.tbl_we, bus.tbl_addr);
        end
        next_cyc();
        #1;
        checks++;
        if (bus.tbl_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_upd_wr: got tbl_we=%b want 1 before reset", bus.tbl_we);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.tbl_en, bus.tbl_we, bus.upd_ready, bus.init_done} !== 4'b0010) begin
            errors++;
            $display("FAIL mid_reset: got en/we/upd_ready/init_done=%b%b%b%b want 0010",
                     bus.tbl_en, bus.tbl_we, bus.upd_ready, bus.init_done);
        end
        expect_init_sweep();
        next_cyc();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.tbl_en, bus.tbl_we, bus.tbl_addr} !== {2'b11, 6'd0}) begin
            errors++;
            $display("FAIL mid_restart: got en=%b we=%b addr=%0d want 1 1 0", bus.tbl_en, bus.tbl_we, bus.tbl_addr);
        end
        wait_drain("mid_sweep");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.tbl_en) busy++;
            next_cyc();
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL mid_flush: got %0d port cycles after sweep want 0 (FIFO flushed)", busy);
        end
        do_lookup(32'h10, 6'd4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_init();
        test_lookup();
        test_update_dec();
        test_update_sat();
        test_starve();
        test_reset_mid();
        repeat (3) next_cyc();
        checks++;
        if (exp_wr_q.size() != 0 || exp_pred_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d writes %0d responses outstanding want 0 0",
                     exp_wr_q.size(), exp_pred_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
